// File: rtl/diff_pkg.sv
`default_nettype none
// ============================================================================
// Module   : diff_pkg
// Purpose  : Shared commit-record type and helpers for the difftest packer.
// Revision : 1.0 - initial release
// ============================================================================
package diff_pkg;

    localparam int NSLOT_MAX  = 4;
    localparam int GPR_NUM    = 32;
    localparam int c_xlen_max = 64;

    // One retiring instruction; pc/wdata held at full width, the top slices to XLEN.
    typedef struct packed {
        logic                  valid;
        logic [c_xlen_max-1:0] pc;
        logic [31:0]           instr;
        logic                  skip;
        logic                  tlbfill;
        logic [4:0]            tlbidx;
        logic                  cnt;
        logic [63:0]           timer;
        logic                  wen;
        logic [7:0]            wdest;
        logic [c_xlen_max-1:0] wdata;
        logic                  csr_rstat;
        logic [31:0]           csr_data;
    } commit_rec_t;

    localparam int c_rec_w = $bits(commit_rec_t);

    function automatic logic [2:0] popcount4(input logic [3:0] v);
        return 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
    endfunction

endpackage
`default_nettype wire

// File: rtl/diff_compact.sv
`default_nettype none
// ============================================================================
// Module   : diff_compact
// Purpose  : Combinational compaction of a sparse commit group into slots 0..k-1.
// Revision : 1.0 - initial release
// ============================================================================
module diff_compact
    import diff_pkg::*;
#(
    parameter int NSLOT = 4
) (
    input  logic [NSLOT*c_rec_w-1:0] i_recs,
    output logic [NSLOT*c_rec_w-1:0] o_recs,
    output logic [2:0]               o_count
);

    commit_rec_t w_in   [NSLOT];
    commit_rec_t w_sel  [NSLOT];
    logic [2:0]  w_rank [NSLOT];
    logic [3:0]  w_valid4;

    for (genvar i = 0; i < NSLOT; i++) begin : g_unpack
        assign w_in[i] = i_recs[i*c_rec_w +: c_rec_w];
    end

    always_comb begin
        w_valid4 = '0;
        for (int i = 0; i < NSLOT; i++) begin
            w_valid4[i] = w_in[i].valid;
        end
    end

    // Rank of slot i = number of valid slots older than it.
    always_comb begin
        for (int i = 0; i < NSLOT; i++) begin
            w_rank[i] = popcount4(w_valid4 & 4'((4'd1 << i) - 4'd1));
        end
    end

    always_comb begin
        for (int j = 0; j < NSLOT; j++) begin
            w_sel[j] = '0;
            for (int i = 0; i < NSLOT; i++) begin
                if (w_valid4[i] && (w_rank[i] == 3'(j))) begin
                    w_sel[j] = w_in[i];
                end
            end
            // A non-writing slot reports no destination; r0 is never a real write.
            if (!w_sel[j].wen) begin
                w_sel[j].wdest = '0;
                w_sel[j].wdata = '0;
            end
            if (w_sel[j].wdest == 8'd0) begin
                w_sel[j].wen = 1'b0;
            end
        end
    end

    for (genvar j = 0; j < NSLOT; j++) begin : g_pack
        assign o_recs[j*c_rec_w +: c_rec_w] = w_sel[j];
    end

    assign o_count = popcount4(w_valid4);

endmodule
`default_nettype wire

// File: rtl/diff_commit_packer.sv
`default_nettype none
// ============================================================================
// Module   : diff_commit_packer
// Purpose  : Compacts, registers and counts ROB commits for the difftest bridge,
//            with a GPR snapshot. DIFF_SHADOW_GPR_EN selects the internal shadow
//            file; otherwise arch_gpr is registered alongside the commit slots.
// Revision : 1.0 - initial release
// ============================================================================
module diff_commit_packer
    import diff_pkg::*;
#(
    parameter int NSLOT = 4,
    parameter int XLEN  = 64
) (
    input  logic                    clock,
    input  logic                    reset_n,
`ifndef DIFF_SHADOW_GPR_EN
    input  logic [GPR_NUM*XLEN-1:0] arch_gpr,
`endif
    input  logic [NSLOT-1:0]        cmt_valid,
    input  logic [NSLOT*XLEN-1:0]   cmt_pc,
    input  logic [NSLOT*32-1:0]     cmt_instr,
    input  logic [NSLOT-1:0]        cmt_skip,
    input  logic [NSLOT-1:0]        cmt_tlbfill,
    input  logic [NSLOT*5-1:0]      cmt_tlbidx,
    input  logic [NSLOT-1:0]        cmt_cnt,
    input  logic [NSLOT*64-1:0]     cmt_timer,
    input  logic [NSLOT-1:0]        cmt_wen,
    input  logic [NSLOT*8-1:0]      cmt_wdest,
    input  logic [NSLOT*XLEN-1:0]   cmt_wdata,
    input  logic [NSLOT-1:0]        cmt_csr_rstat,
    input  logic [NSLOT*32-1:0]     cmt_csr_data,
    output logic [NSLOT-1:0]        out_valid,
    output logic [NSLOT*XLEN-1:0]   out_pc,
    output logic [NSLOT*32-1:0]     out_instr,
    output logic [NSLOT-1:0]        out_skip,
    output logic [NSLOT-1:0]        out_tlbfill,
    output logic [NSLOT*5-1:0]      out_tlbidx,
    output logic [NSLOT-1:0]        out_cnt,
    output logic [NSLOT*64-1:0]     out_timer,
    output logic [NSLOT-1:0]        out_wen,
    output logic [NSLOT*8-1:0]      out_wdest,
    output logic [NSLOT*XLEN-1:0]   out_wdata,
    output logic [NSLOT-1:0]        out_csr_rstat,
    output logic [NSLOT*32-1:0]     out_csr_data,
    output logic [NSLOT*8-1:0]      out_index,
    output logic [GPR_NUM*XLEN-1:0] gpr_flat,
    output logic [63:0]             retired_cnt
);

    commit_rec_t               w_rec_in [NSLOT];
    commit_rec_t               w_pack   [NSLOT];
    commit_rec_t               r_slot   [NSLOT];
    logic [NSLOT*c_rec_w-1:0]  w_in_flat;
    logic [NSLOT*c_rec_w-1:0]  w_pack_flat;
    logic [2:0]                w_count;
    logic [63:0]               r_retired_cnt;

    always_comb begin
        w_in_flat = '0;
        for (int i = 0; i < NSLOT; i++) begin
            w_rec_in[i]           = '0;
            w_rec_in[i].valid     = cmt_valid[i];
            w_rec_in[i].pc        = c_xlen_max'(cmt_pc[i*XLEN +: XLEN]);
            w_rec_in[i].instr     = cmt_instr[i*32 +: 32];
            w_rec_in[i].skip      = cmt_skip[i];
            w_rec_in[i].tlbfill   = cmt_tlbfill[i];
            w_rec_in[i].tlbidx    = cmt_tlbidx[i*5 +: 5];
            w_rec_in[i].cnt       = cmt_cnt[i];
            w_rec_in[i].timer     = cmt_timer[i*64 +: 64];
            w_rec_in[i].wen       = cmt_wen[i];
            w_rec_in[i].wdest     = cmt_wdest[i*8 +: 8];
            w_rec_in[i].wdata     = c_xlen_max'(cmt_wdata[i*XLEN +: XLEN]);
            w_rec_in[i].csr_rstat = cmt_csr_rstat[i];
            w_rec_in[i].csr_data  = cmt_csr_data[i*32 +: 32];
            w_in_flat[i*c_rec_w +: c_rec_w] = w_rec_in[i];
        end
    end

    diff_compact #(
        .NSLOT (NSLOT)
    ) u_compact (
        .i_recs  (w_in_flat),
        .o_recs  (w_pack_flat),
        .o_count (w_count)
    );

    always_comb begin
        for (int j = 0; j < NSLOT; j++) begin
            w_pack[j] = w_pack_flat[j*c_rec_w +: c_rec_w];
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int j = 0; j < NSLOT; j++) begin
                r_slot[j] <= '0;
            end
            r_retired_cnt <= '0;
        end else begin
            for (int j = 0; j < NSLOT; j++) begin
                r_slot[j] <= w_pack[j];
            end
            r_retired_cnt <= r_retired_cnt + 64'(w_count);
        end
    end

`ifdef DIFF_SHADOW_GPR_EN
    logic [XLEN-1:0] r_gpr [GPR_NUM];

    // Packed slots keep age order, so the last matching write in the loop is the youngest.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int r = 0; r < GPR_NUM; r++) begin
                r_gpr[r] <= '0;
            end
        end else begin
            for (int j = 0; j < NSLOT; j++) begin
                if (w_pack[j].valid && w_pack[j].wen && (w_pack[j].wdest[4:0] != 5'd0)) begin
                    r_gpr[w_pack[j].wdest[4:0]] <= w_pack[j].wdata[XLEN-1:0];
                end
            end
        end
    end

    for (genvar r = 0; r < GPR_NUM; r++) begin : g_gpr_out
        assign gpr_flat[r*XLEN +: XLEN] = r_gpr[r];
    end
`else
    logic [GPR_NUM*XLEN-1:0] r_gpr_flat;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_gpr_flat <= '0;
        end else begin
            r_gpr_flat <= arch_gpr;
        end
    end

    assign gpr_flat = r_gpr_flat;
`endif

    for (genvar j = 0; j < NSLOT; j++) begin : g_out
        assign out_valid[j]                = r_slot[j].valid;
        assign out_pc[j*XLEN +: XLEN]      = r_slot[j].pc[XLEN-1:0];
        assign out_instr[j*32 +: 32]       = r_slot[j].instr;
        assign out_skip[j]                 = r_slot[j].skip;
        assign out_tlbfill[j]              = r_slot[j].tlbfill;
        assign out_tlbidx[j*5 +: 5]        = r_slot[j].tlbidx;
        assign out_cnt[j]                  = r_slot[j].cnt;
        assign out_timer[j*64 +: 64]       = r_slot[j].timer;
        assign out_wen[j]                  = r_slot[j].wen;
        assign out_wdest[j*8 +: 8]         = r_slot[j].wdest;
        assign out_wdata[j*XLEN +: XLEN]   = r_slot[j].wdata[XLEN-1:0];
        assign out_csr_rstat[j]            = r_slot[j].csr_rstat;
        assign out_csr_data[j*32 +: 32]    = r_slot[j].csr_data;
        assign out_index[j*8 +: 8]         = 8'(j);
    end

    assign retired_cnt = r_retired_cnt;

endmodule
`default_nettype wire
